// File: rtl/pe_sink.sv
// pe_sink: network-on-chip sink endpoint. Accepts 32-bit flits addressed to
// ADDRESS into a circular receive buffer and presents the 24-bit payloads to a
// local consumer over a valid/ready pair. It discards flits for other
// addresses, counts them, and can optionally throttle the drain side with an
// LFSR gate.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   i_data        flit: [31:24] destination address, [23:0] payload
//   i_data_valid  flit on i_data is valid
//   o_data_ready  sink can accept a flit this cycle (registered)
//   o_rx_data     payload at buffer head, 0 when empty
//   o_rx_valid    head payload valid and poppable this cycle
//   i_rx_ready    consumer takes head payload
//   o_fifo_level  current buffer occupancy
//   o_pkt_count   saturating count of accepted matching flits
//   o_err_count   saturating count of accepted mismatching flits
module pe_sink #(
    parameter logic [7:0]  ADDRESS    = 8'd0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          STALL_EN   = 1'b0,
    parameter logic [7:0]  STALL_SEED = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   i_data,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    output logic [23:0]                   o_rx_data,
    output logic                          o_rx_valid,
    input  logic                          i_rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [15:0]                   o_pkt_count,
    output logic [15:0]                   o_err_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned PAY_W = 24;
    localparam int unsigned CNT_W = 16;

    logic [PAY_W-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] remain;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             ready_q, ready_d;
    logic             rx_valid_q, rx_valid_d;
    logic [PAY_W-1:0] rx_data_q, rx_data_d;
    logic             accept;
    logic             hit;
    logic             miss;
    logic             pop;
    logic             gate_d;

    // Next-state: handshakes, pointers, occupancy, counters, LFSR and the
    // registered view of the head that the outputs present next cycle.
    always_comb begin
        accept     = i_data_valid & ready_q;
        hit        = accept & (i_data[31:24] == ADDRESS);
        miss       = accept & (i_data[31:24] != ADDRESS);
        pop        = rx_valid_q & i_rx_ready;

        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(hit);
        remain     = level_q - LVL_W'(pop);
        level_d    = remain + LVL_W'(hit);

        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (hit && (pkt_cnt_q != {CNT_W{1'b1}})) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
        if (miss && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1.
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        gate_d     = STALL_EN ? lfsr_d[0] : 1'b1;

        // Full buffer keeps ready low through a same-cycle pop; ready
        // follows the post-edge occupancy.
        ready_d    = (level_d < LVL_W'(FIFO_DEPTH));
        rx_valid_d = (level_d != '0) & gate_d;

        // If nothing older survives the pop, the incoming flit becomes the
        // head; bypass it since the memory write lands on the same edge.
        rx_data_d  = '0;
        if (level_d != '0) begin
            if (remain == '0) begin
                rx_data_d = i_data[PAY_W-1:0];
            end else begin
                rx_data_d = mem[rd_ptr_d];
            end
        end
    end

    // Control and output state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            lfsr_q     <= STALL_SEED;
            ready_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            lfsr_q     <= lfsr_d;
            ready_q    <= ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Payload storage; contents are don't-care until covered by level.
    always_ff @(posedge clk) begin
        if (hit) begin
            mem[wr_ptr_q] <= i_data[PAY_W-1:0];
        end
    end

    assign o_data_ready = ready_q;
    assign o_rx_valid   = rx_valid_q;
    assign o_rx_data    = rx_data_q;
    assign o_fifo_level = level_q;
    assign o_pkt_count  = pkt_cnt_q;
    assign o_err_count  = err_cnt_q;

endmodule

// File: tb/tb_pe_sink.sv
// Bench for pe_sink: instance 0 runs unthrottled, instance 1 runs with the
// LFSR drain gate. Each instance has a queue-based reference model.
module tb_pe_sink;

    logic        clk;
    logic        rst;
    logic [31:0] din  [2];
    logic        dv   [2];
    logic        rr   [2];
    logic        rdy  [2];
    logic [23:0] rxd  [2];
    logic        vld  [2];
    logic [2:0]  lvl  [2];
    logic [15:0] pkt  [2];
    logic [15:0] err  [2];

    pe_sink #(.ADDRESS(8'd3), .FIFO_DEPTH(4), .STALL_EN(1'b0), .STALL_SEED(8'hA5)) u_dut0 (
        .clk(clk), .rst(rst), .i_data(din[0]), .i_data_valid(dv[0]),
        .o_data_ready(rdy[0]), .o_rx_data(rxd[0]), .o_rx_valid(vld[0]),
        .i_rx_ready(rr[0]), .o_fifo_level(lvl[0]), .o_pkt_count(pkt[0]),
        .o_err_count(err[0]));

    pe_sink #(.ADDRESS(8'd3), .FIFO_DEPTH(4), .STALL_EN(1'b1), .STALL_SEED(8'hA5)) u_dut1 (
        .clk(clk), .rst(rst), .i_data(din[1]), .i_data_valid(dv[1]),
        .o_data_ready(rdy[1]), .o_rx_data(rxd[1]), .o_rx_valid(vld[1]),
        .i_rx_ready(rr[1]), .o_fifo_level(lvl[1]), .o_pkt_count(pkt[1]),
        .o_err_count(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance.
    logic [23:0] sbq [2][$];
    int          m_pkt  [2];
    int          m_err  [2];
    logic [7:0]  m_lfsr [2];
    bit          m_live [2];
    int          got_cnt  [2];
    logic [23:0] last_got [2];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Monitor: compare outputs against the model, then advance the model
    // by whatever the coming rising edge will do.
    always @(negedge clk) begin
        logic        exp_rdy;
        logic        exp_vld;
        logic [23:0] exp_dat;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                sbq[k].delete();
                m_pkt[k]  = 0;
                m_err[k]  = 0;
                m_lfsr[k] = 8'hA5;
                m_live[k] = 1'b0;
            end
            exp_rdy = m_live[k] && (sbq[k].size() < 4);
            exp_vld = (sbq[k].size() != 0) && ((k == 0) || m_lfsr[k][0]);
            exp_dat = (sbq[k].size() != 0) ? sbq[k][0] : 24'd0;
            chk("level", k, 32'(lvl[k]), 32'(sbq[k].size()));
            chk("data_ready", k, 32'(rdy[k]), 32'(exp_rdy));
            chk("rx_valid", k, 32'(vld[k]), 32'(exp_vld));
            chk("rx_data", k, 32'(rxd[k]), 32'(exp_dat));
            chk("pkt_count", k, 32'(pkt[k]), 32'(m_pkt[k]));
            chk("err_count", k, 32'(err[k]), 32'(m_err[k]));
            if (rst) begin
                if (exp_vld && rr[k]) begin
                    last_got[k] = sbq[k].pop_front();
                    got_cnt[k]++;
                end
                if (dv[k] && exp_rdy) begin
                    if (din[k][31:24] == 8'd3) begin
                        sbq[k].push_back(din[k][23:0]);
                        if (m_pkt[k] < 65535) m_pkt[k]++;
                    end else begin
                        if (m_err[k] < 65535) m_err[k]++;
                    end
                end
                m_lfsr[k] = lfsr_next(m_lfsr[k]);
                m_live[k] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a flit and hold it until the sink accepts it.
    task automatic send(input int k, input logic [31:0] flit);
        bit acc;
        acc = 1'b0;
        din[k] = flit;
        dv[k]  = 1'b1;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            acc = rdy[k];
            tick();
        end
        dv[k] = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout[%0d]: flit %h never accepted", k, flit);
        end
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 2000 && sbq[k].size() != 0; i++) tick();
        chk("drain", k, 32'(sbq[k].size()), 32'd0);
    endtask

    bit stall_done;
    int got_base;

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            din[k] = '0; dv[k] = 1'b0; rr[k] = 1'b0;
            got_cnt[k] = 0; last_got[k] = '0;
        end
        repeat (3) tick();
        rst = 1'b1;

        // Back-to-back matching flits with consumer always ready.
        rr[0] = 1'b1;
        for (int i = 0; i < 5; i++) send(0, {8'd3, 24'(300 + i)});
        drain(0);
        tick();
        chk("t1_pkt", 0, 32'(pkt[0]), 32'd5);
        chk("t1_err", 0, 32'(err[0]), 32'd0);
        chk("t1_got", 0, 32'(got_cnt[0]), 32'd5);
        chk("t1_last", 0, 32'(last_got[0]), 32'd304);

        // Mismatching destination is consumed but dropped.
        send(0, {8'd7, 24'd700});
        send(0, {8'd3, 24'd301});
        drain(0);
        tick();
        chk("t2_pkt", 0, 32'(pkt[0]), 32'd6);
        chk("t2_err", 0, 32'(err[0]), 32'd1);
        chk("t2_got", 0, 32'(got_cnt[0]), 32'd6);
        chk("t2_last", 0, 32'(last_got[0]), 32'd301);

        // Backpressure: buffer fills to depth, then drains.
        rr[0] = 1'b0;
        got_base = got_cnt[0];
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, {8'd3, 24'(400 + i)});
            end
            begin
                repeat (12) tick();
                chk("t3_full_level", 0, 32'(lvl[0]), 32'd4);
                chk("t3_full_ready", 0, 32'(rdy[0]), 32'd0);
                rr[0] = 1'b1;
            end
        join
        drain(0);
        tick();
        chk("t3_got", 0, 32'(got_cnt[0] - got_base), 32'd6);
        chk("t3_last", 0, 32'(last_got[0]), 32'd405);

        // Randomized mixed traffic on the unthrottled instance.
        for (int i = 0; i < 300; i++) begin
            din[0] = {(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'd3), 24'($urandom)};
            dv[0]  = 1'($urandom_range(0, 1));
            rr[0]  = ($urandom_range(0, 3) != 0);
            tick();
        end
        dv[0] = 1'b0;
        rr[0] = 1'b1;
        drain(0);

        // Counter saturation.
        force u_dut0.pkt_cnt_q = 16'hFFFE;
        m_pkt[0] = 32'hFFFE;
        tick();
        release u_dut0.pkt_cnt_q;
        for (int i = 0; i < 3; i++) send(0, {8'd3, 24'(500 + i)});
        drain(0);
        tick();
        chk("sat_pkt", 0, 32'(pkt[0]), 32'hFFFF);

        // Asynchronous reset mid-operation.
        rr[0] = 1'b0;
        for (int i = 0; i < 3; i++) send(0, {8'd3, 24'(600 + i)});
        send(0, {8'd9, 24'd900});
        chk("pre_rst_level", 0, 32'(lvl[0]), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("rst_level", 0, 32'(lvl[0]), 32'd0);
        chk("rst_ready", 0, 32'(rdy[0]), 32'd0);
        chk("rst_valid", 0, 32'(vld[0]), 32'd0);
        chk("rst_data", 0, 32'(rxd[0]), 32'd0);
        chk("rst_pkt", 0, 32'(pkt[0]), 32'd0);
        chk("rst_err", 0, 32'(err[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        got_base = got_cnt[0];
        rr[0] = 1'b1;
        send(0, {8'd3, 24'd777});
        drain(0);
        repeat (2) tick();
        chk("post_rst_got", 0, 32'(got_cnt[0] - got_base), 32'd1);
        chk("post_rst_last", 0, 32'(last_got[0]), 32'd777);
        chk("post_rst_pkt", 0, 32'(pkt[0]), 32'd1);
        chk("post_rst_err", 0, 32'(err[0]), 32'd0);

        // Throttled drain with random consumer readiness over 1000 flits.
        got_base = got_cnt[1];
        stall_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) send(1, {8'd3, 24'(i)});
                stall_done = 1'b1;
            end
            begin
                while (!stall_done) begin
                    rr[1] = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        rr[1] = 1'b1;
        drain(1);
        tick();
        chk("stall_got", 1, 32'(got_cnt[1] - got_base), 32'd1000);
        chk("stall_last", 1, 32'(last_got[1]), 32'd999);
        chk("stall_pkt", 1, 32'(pkt[1]), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
